// File: rtl/sb_pkt_router.sv
// Single-input, N-output packet router: low byte of the header beat picks the port; packets to absent ports are dropped.
// One registered output stage (1-cycle latency); forwarded beats wait on the selected out_ready, dropped beats never wait.
module sb_pkt_router #(
  parameter int DW = 256,
  parameter int N  = 2,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [N-1:0]  out_valid,
  input  logic [N-1:0]  out_ready,
  output logic [CW-1:0] pkt_count,
  output logic [CW-1:0] drop_count
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

  state_t        state_q;
  logic [PW-1:0] sel_q;
  logic          vreg_q;
  logic [DW-1:0] dreg_q;
  logic          lreg_q;
  logic [PW-1:0] preg_q;
  logic [CW-1:0] pkt_q, pkt_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [7:0]    dest;
  logic          dest_ok;
  logic [PW-1:0] dest_port;
  logic          is_idle;
  logic          drop_beat;
  logic          out_rdy_sel;
  logic          unload;
  logic          accept;
  logic          fwd;
  logic [PW-1:0] fwd_port;

  assign dest        = in_data[7:0];
  assign dest_ok     = ({1'b0, dest} < 9'(N));
  assign dest_port   = dest[PW-1:0];
  assign is_idle     = (state_q == IDLE);
  // A dropped beat is either mid-drop or a header aimed at a port that does not exist.
  assign drop_beat   = (state_q == DROP) | (is_idle & ~dest_ok);
  assign out_rdy_sel = out_ready[preg_q];
  assign unload      = vreg_q & out_rdy_sel;
  assign in_ready    = nreset & (drop_beat | ~vreg_q | out_rdy_sel);
  assign accept      = in_valid & in_ready;
  assign fwd         = accept & ~drop_beat;
  assign fwd_port    = is_idle ? dest_port : sel_q;

  always_comb begin
    pkt_d  = pkt_q;
    drop_d = drop_q;
    if (unload && lreg_q) begin
      pkt_d = pkt_q + CW'(1);
    end
    if (accept && drop_beat && in_last && (drop_q != '1)) begin
      drop_d = drop_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      vreg_q  <= 1'b0;
      dreg_q  <= '0;
      lreg_q  <= 1'b0;
      preg_q  <= '0;
      pkt_q   <= '0;
      drop_q  <= '0;
    end else begin
      pkt_q  <= pkt_d;
      drop_q <= drop_d;

      // Load has priority over unload so a drain and a new beat share one cycle.
      if (fwd) begin
        vreg_q <= 1'b1;
        dreg_q <= in_data;
        lreg_q <= in_last;
        preg_q <= fwd_port;
      end else if (unload) begin
        vreg_q <= 1'b0;
      end

      if (accept) begin
        case (state_q)
          IDLE: begin
            if (!in_last) begin
              if (dest_ok) begin
                sel_q   <= dest_port;
                state_q <= BODY;
              end else begin
                state_q <= DROP;
              end
            end
          end
          BODY, DROP: begin
            if (in_last) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    out_valid = '0;
    for (int i = 0; i < N; i++) begin
      out_valid[i] = vreg_q && (preg_q == PW'(i));
    end
  end

  assign out_data   = dreg_q;
  assign out_last   = lreg_q;
  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;

  a_onehot: assert property (@(posedge clk) disable iff (!nreset) $onehot0(out_valid));
  a_hold: assert property (@(posedge clk) disable iff (!nreset)
    (vreg_q && !out_rdy_sel) |=> (vreg_q && $stable(dreg_q) && $stable(lreg_q) && $stable(preg_q)));

endmodule
